// File: rtl/main_memory_responder.sv
// ============================================================================
// main_memory_responder
// Fixed-latency word-addressed backing store for the L3 cache miss path.
// Revision: 1.0
// ============================================================================
`default_nettype none

module main_memory_responder #(
    parameter int MAIN_MEMORY_ADDRESS_WIDTH = 32,
    parameter int MAIN_MEMORY_DATA_WIDTH    = 32,
    parameter int DEPTH                     = 1024,
    parameter int READ_LATENCY              = 4,
    parameter int WRITE_LATENCY             = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 main_memory_read_request,
    input  logic                                 main_memory_write_request,
    input  logic [MAIN_MEMORY_ADDRESS_WIDTH-1:0] main_memory_address,
    input  logic [MAIN_MEMORY_DATA_WIDTH-1:0]    main_memory_write_data,
    output logic [MAIN_MEMORY_DATA_WIDTH-1:0]    main_memory_read_data,
    output logic                                 main_memory_ready,
    output logic                                 main_memory_busy,
    output logic                                 protocol_error
);

    localparam int IDX_W   = $clog2(DEPTH);
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;
    localparam logic [CNT_W-1:0] C_READ_LOAD  = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] C_WRITE_LOAD = CNT_W'(WRITE_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESPOND = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t                            state_q, state_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic [IDX_W-1:0]                  idx_q, idx_d;
    logic [MAIN_MEMORY_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                              op_write_q, op_write_d;
    logic [MAIN_MEMORY_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                              ready_q, ready_d;
    logic                              busy_q, busy_d;
    logic                              perr_q, perr_d;
    logic                              mem_we;
    logic [MAIN_MEMORY_DATA_WIDTH-1:0] mem_q [DEPTH];

    if (MAIN_MEMORY_ADDRESS_WIDTH > IDX_W) begin : g_alias_bits
        logic unused_addr_bits;
        assign unused_addr_bits = ^main_memory_address[MAIN_MEMORY_ADDRESS_WIDTH-1:IDX_W];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        op_write_d = op_write_q;
        rdata_d    = rdata_q;
        ready_d    = 1'b0;
        perr_d     = 1'b0;
        mem_we     = 1'b0;
        case (state_q)
            // The edge ending RECOVER is already an acceptance edge, so a requester
            // that switches op right after ready is taken at N+LAT+2.
            IDLE, RECOVER: begin
                if (main_memory_read_request || main_memory_write_request) begin
                    idx_d      = main_memory_address[IDX_W-1:0];
                    wdata_d    = main_memory_write_data;
                    op_write_d = main_memory_write_request;
                    cnt_d      = main_memory_write_request ? C_WRITE_LOAD : C_READ_LOAD;
                    perr_d     = main_memory_read_request && main_memory_write_request;
                    state_d    = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    if (op_write_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = mem_q[idx_q];
                    end
                    ready_d = 1'b1;
                    state_d = RESPOND;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESPOND: state_d = RECOVER;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            op_write_q <= 1'b0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            op_write_q <= op_write_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            perr_q     <= perr_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign main_memory_read_data = rdata_q;
    assign main_memory_ready     = ready_q;
    assign main_memory_busy      = busy_q;
    assign protocol_error        = perr_q;

endmodule

`default_nettype wire

// File: tb/tb_main_memory_responder.sv
// ============================================================================
// tb_main_memory_responder
// Directed vector bench: READ_LATENCY=1, WRITE_LATENCY=4, DEPTH=1024.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_main_memory_responder;

    localparam int C_RLAT = 1;
    localparam int C_WLAT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd_req = 1'b0;
    logic        wr_req = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        perr;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] last_rd = '0;

    main_memory_responder #(
        .MAIN_MEMORY_ADDRESS_WIDTH(32),
        .MAIN_MEMORY_DATA_WIDTH   (32),
        .DEPTH                    (1024),
        .READ_LATENCY             (C_RLAT),
        .WRITE_LATENCY            (C_WLAT)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .main_memory_read_request (rd_req),
        .main_memory_write_request(wr_req),
        .main_memory_address      (addr),
        .main_memory_write_data   (wdata),
        .main_memory_read_data    (rdata),
        .main_memory_ready        (ready),
        .main_memory_busy         (busy),
        .protocol_error           (perr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        int          exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete transaction; requests held until ready, then dropped.
    task automatic run_op(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd, input int exp_err);
        int k;
        int errs;
        int lat;
        lat = wr ? C_WLAT : C_RLAT;
        @(posedge clk); #1;
        rd_req = rd; wr_req = wr; addr = a; wdata = d;
        @(posedge clk); #1;
        check("busy_after_sample", {31'b0, busy}, 32'd1);
        errs = perr ? 1 : 0;
        k = 0;
        while (!ready && k < 20) begin
            @(posedge clk); #1;
            k++;
            if (perr) errs++;
        end
        check("ready_latency", k, lat);
        if (!wr) last_rd = exp_rd;
        check("read_data", rdata, last_rd);
        rd_req = 1'b0; wr_req = 1'b0;
        @(posedge clk); #1;
        if (perr) errs++;
        check("ready_one_cycle", {31'b0, ready}, 32'd0);
        check("busy_recover", {31'b0, busy}, 32'd1);
        @(posedge clk); #1;
        if (perr) errs++;
        check("busy_idle", {31'b0, busy}, 32'd0);
        check("protocol_error_count", errs, exp_err);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         32'h0000_0000, 0};
        vecs[3]  = '{1'b1, 1'b1, 32'h0000_0005, 32'hA5A5_A5A5, 32'h0, 1};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_0005, 32'h0,         32'hA5A5_A5A5, 0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_0405, 32'h0,         32'hA5A5_A5A5, 0};
        vecs[6]  = '{1'b0, 1'b1, 32'h0000_0805, 32'h0BAD_F00D, 32'h0, 0};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_0005, 32'h0,         32'h0BAD_F00D, 0};
        vecs[8]  = '{1'b0, 1'b1, 32'h0000_03FF, 32'h1111_2222, 32'h0, 0};
        vecs[9]  = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0,         32'h1111_2222, 0};
        vecs[10] = '{1'b0, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 32'h0, 0};
        vecs[11] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hCAFE_F00D, 0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", {31'b0, ready}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_perr", {31'b0, perr}, 32'd0);
        check("reset_rdata", rdata, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data,
                   vecs[i].exp_rd, vecs[i].exp_err);
        end

        // Write then read raised the cycle after ready: accepted at N+LAT+2.
        @(posedge clk); #1;
        wr_req = 1'b1; addr = 32'h30; wdata = 32'h1234_5678;
        @(posedge clk); #1;
        repeat (C_WLAT) @(posedge clk);
        #1;
        check("chain_write_ready", {31'b0, ready}, 32'd1);
        wr_req = 1'b0;
        @(posedge clk); #1;
        rd_req = 1'b1; addr = 32'h30;
        @(posedge clk); #1;
        check("chain_read_accepted", {31'b0, busy}, 32'd1);
        check("chain_no_error", {31'b0, perr}, 32'd0);
        repeat (C_RLAT) @(posedge clk);
        #1;
        check("chain_read_ready", {31'b0, ready}, 32'd1);
        check("chain_read_data", rdata, 32'h1234_5678);
        last_rd = 32'h1234_5678;
        rd_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("chain_idle", {31'b0, busy}, 32'd0);

        // Request dropped right after its sample edge still completes.
        @(posedge clk); #1;
        wr_req = 1'b1; addr = 32'h40; wdata = 32'h55AA_55AA;
        @(posedge clk); #1;
        wr_req = 1'b0;
        repeat (C_WLAT - 1) @(posedge clk);
        #1;
        check("drop_not_ready_early", {31'b0, ready}, 32'd0);
        @(posedge clk); #1;
        check("drop_ready", {31'b0, ready}, 32'd1);
        repeat (2) @(posedge clk);
        run_op(1'b1, 1'b0, 32'h40, 32'h0, 32'h55AA_55AA, 0);

        // Reset mid-write aborts it and clears the array.
        @(posedge clk); #1;
        wr_req = 1'b1; addr = 32'h7; wdata = 32'hFFFF_0000;
        repeat (2) @(posedge clk);
        #1;
        check("abort_busy_before", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_ready", {31'b0, ready}, 32'd0);
        check("abort_rdata", rdata, 32'h0);
        wr_req = 1'b0;
        @(posedge clk); #3;
        reset = 1'b0;
        last_rd = 32'h0;
        run_op(1'b1, 1'b0, 32'h7, 32'h0, 32'h0000_0000, 0);
        run_op(1'b1, 1'b0, 32'h10, 32'h0, 32'h0000_0000, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
